// File: rtl/reaction_game_ctrl_pkg.sv
// Shared types and constants for the reaction-game controller: state encoding,
// counter width and the delay LFSR step.
package reaction_game_ctrl_pkg;
  localparam int COUNT_W = 13;
  localparam logic [COUNT_W-1:0] MS_MAX = 13'h1FFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_t;

  // Fibonacci x^16+x^14+x^13+x^11, shifting toward the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
endpackage

// File: rtl/reaction_delay_lfsr.sv
// Free-running 16-bit LFSR that supplies the random part of the fore-period.
module reaction_delay_lfsr
  import reaction_game_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] lfsr
);
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= SEED;
    else       lfsr <= lfsr_next(lfsr);
  end
endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: random fore-period, GO light, reaction timing via the
// external ms counter. Define REACTION_BEST_TIME_EN to add the BestTime tracker.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_MASK   = 2047,
  parameter int unsigned TIMEOUT_MS   = 8191,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               MsTick,
  input  logic               Start,
  input  logic               Button,
  input  logic [COUNT_W-1:0] Count,
  output logic               CntEnable,
  output logic               CntReset,
  output logic               GoLed,
  output logic               Busy,
  output logic [COUNT_W-1:0] Result,
  output logic               ResultValid,
  output logic               FalseStart
`ifdef REACTION_BEST_TIME_EN
  ,
  output logic [COUNT_W-1:0] BestTime
`endif
);
  localparam logic [COUNT_W-1:0] MIN_D   = COUNT_W'(MIN_DELAY_MS);
  localparam logic [COUNT_W-1:0] MASK_D  = COUNT_W'(DELAY_MASK);
  localparam logic [COUNT_W-1:0] TMO_C   = COUNT_W'(TIMEOUT_MS);

  state_t             state, state_nx;
  logic               start_q, button_q;
  logic               start_edge, button_edge;
  logic [COUNT_W-1:0] delay_ms;
  logic [15:0]        lfsr;
  logic               lfsr_unused;
  logic               load_delay, load_result;
  logic [COUNT_W-1:0] result_nx;

  reaction_delay_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .lfsr  (lfsr)
  );

  // the delay only ever needs the low COUNT_W bits of the LFSR
  assign lfsr_unused = ^lfsr[15:COUNT_W];

  assign start_edge  = Start  & ~start_q;
  assign button_edge = Button & ~button_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      button_q   <= 1'b0;
      delay_ms   <= '0;
      Result     <= '0;
      FalseStart <= 1'b0;
    end else begin
      state    <= state_nx;
      start_q  <= Start;
      button_q <= Button;
      if (load_delay)                 delay_ms <= MIN_D + (lfsr[COUNT_W-1:0] & MASK_D);
      else if (state == ST_ARM && MsTick) delay_ms <= delay_ms - COUNT_W'(1);
      if (load_result) Result <= result_nx;
      if (state == ST_FOUL) FalseStart <= 1'b1;
      else if (load_delay)  FalseStart <= 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    CntEnable   = 1'b0;
    CntReset    = 1'b1;
    GoLed       = 1'b0;
    Busy        = 1'b0;
    ResultValid = 1'b0;
    load_delay  = 1'b0;
    load_result = 1'b0;
    result_nx   = Count;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nx   = ST_ARM;
          load_delay = 1'b1;
        end
      end
      ST_ARM: begin
        Busy = 1'b1;
        if (button_edge)                   state_nx = ST_FOUL;
        else if (MsTick && delay_ms == '0) state_nx = ST_GO;
      end
      ST_GO: begin
        Busy      = 1'b1;
        GoLed     = 1'b1;
        CntReset  = 1'b0;
        CntEnable = MsTick;
        // a press on the timeout cycle still counts as a press
        if (button_edge) begin
          state_nx    = ST_DONE;
          load_result = 1'b1;
        end else if (Count == TMO_C) begin
          state_nx    = ST_DONE;
          load_result = 1'b1;
          result_nx   = TMO_C;
        end
      end
      ST_DONE: begin
        CntReset    = 1'b0;
        ResultValid = 1'b1;
        state_nx    = ST_IDLE;
      end
      ST_FOUL: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef REACTION_BEST_TIME_EN
  logic timeout_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      BestTime  <= MS_MAX;
      timeout_q <= 1'b0;
    end else begin
      if (load_result) timeout_q <= ~button_edge;
      if (state == ST_DONE && !timeout_q && Result < BestTime) BestTime <= Result;
    end
  end
`endif
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with a round-level reference model and a
// second instance that exposes the random fore-period.
module tb_reaction_game_ctrl;
  import reaction_game_ctrl_pkg::*;

  localparam int          MIN_D  = 1000;
  localparam int          M_MASK = 0;
  localparam int          TMO    = 8191;
  localparam int          R_MIN  = 3;
  localparam int          R_MASK = 31;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int P_IDLE = 0, P_WAIT = 1, P_LIT = 2, P_REPORT = 3, P_FOUL = 4;

  logic        Clock = 1'b0, Reset = 1'b1, MsTick = 1'b0, Start = 1'b0, Button = 1'b0;
  logic [12:0] Count = '0;
  logic        CntEnable, CntReset, GoLed, Busy, ResultValid, FalseStart;
  logic [12:0] Result;
  logic        start2 = 1'b0, button2 = 1'b0;
  logic [12:0] count2 = '0;
  logic        cen2, crst2, go2, busy2, rv2, fs2;
  logic [12:0] res2;
`ifdef REACTION_BEST_TIME_EN
  logic [12:0] BestTime, BestTime2;
`endif

  reaction_game_ctrl #(.MIN_DELAY_MS(MIN_D), .DELAY_MASK(M_MASK), .TIMEOUT_MS(TMO),
                       .LFSR_SEED(SEED)) dut (
    .Clock(Clock), .Reset(Reset), .MsTick(MsTick), .Start(Start), .Button(Button),
    .Count(Count), .CntEnable(CntEnable), .CntReset(CntReset), .GoLed(GoLed),
    .Busy(Busy), .Result(Result), .ResultValid(ResultValid), .FalseStart(FalseStart)
`ifdef REACTION_BEST_TIME_EN
    , .BestTime(BestTime)
`endif
  );

  reaction_game_ctrl #(.MIN_DELAY_MS(R_MIN), .DELAY_MASK(R_MASK), .TIMEOUT_MS(TMO),
                       .LFSR_SEED(SEED)) u_rnd (
    .Clock(Clock), .Reset(Reset), .MsTick(MsTick), .Start(start2), .Button(button2),
    .Count(count2), .CntEnable(cen2), .CntReset(crst2), .GoLed(go2),
    .Busy(busy2), .Result(res2), .ResultValid(rv2), .FalseStart(fs2)
`ifdef REACTION_BEST_TIME_EN
    , .BestTime(BestTime2)
`endif
  );

  always #5 Clock = ~Clock;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // 1 kHz strobe stand-in: one cycle high, one cycle low
  initial forever begin
    @(posedge Clock); #1 MsTick = ~MsTick;
  end

  // external 13-bit counter driven by the controller
  logic cr_s, ce_s;
  initial forever begin
    @(negedge Clock); cr_s = CntReset; ce_s = CntEnable;
    @(posedge Clock); #1;
    if (cr_s)      Count = '0;
    else if (ce_s) Count = Count + 13'd1;
  end

  // reference model: round phase, ticks still owed before the light, reported values
  int          ph = P_IDLE, ticks_left = 0, exp_arm2 = -1;
  logic [12:0] m_res = '0, m_best = MS_MAX;
  logic        m_fs = 1'b0, m_tmo = 1'b0, m_live = 1'b0;
  logic        m_sprev = 1'b0, m_bprev = 1'b0, m_s2prev = 1'b0, m_se, m_be;
  logic [15:0] m_lfsr = SEED;

  initial forever begin
    @(negedge Clock);
    if (m_live) begin
      check("GoLed", GoLed, ph == P_LIT);
      check("Busy", Busy, ph == P_WAIT || ph == P_LIT);
      check("ResultValid", ResultValid, ph == P_REPORT);
      check("Result", Result, m_res);
      check("FalseStart", FalseStart, m_fs);
      if (ph == P_IDLE || ph == P_WAIT) begin
        check("CntReset", CntReset, 1);
        check("CntEnable", CntEnable, 0);
      end else if (ph == P_LIT) begin
        check("CntReset", CntReset, 0);
        check("CntEnable", CntEnable, MsTick);
      end else if (ph == P_REPORT) check("CntEnable", CntEnable, 0);
`ifdef REACTION_BEST_TIME_EN
      check("BestTime", BestTime, m_best);
`endif
    end
    m_se = Start & ~m_sprev;
    m_be = Button & ~m_bprev;
    if (start2 && !m_s2prev) exp_arm2 = R_MIN + int'(m_lfsr & 16'(R_MASK)) + 1;
    if (Reset) begin
      ph = P_IDLE; m_res = '0; m_fs = 1'b0; m_best = MS_MAX; m_live = 1'b1;
    end else begin
      case (ph)
        P_IDLE: if (m_se) begin
          ph = P_WAIT; m_fs = 1'b0;
          ticks_left = MIN_D + int'(m_lfsr & 16'(M_MASK)) + 1;
        end
        P_WAIT: if (m_be) ph = P_FOUL;
                else if (MsTick) begin
                  ticks_left--;
                  if (ticks_left == 0) ph = P_LIT;
                end
        P_LIT: if (m_be) begin
                 ph = P_REPORT; m_res = Count; m_tmo = 1'b0;
               end else if (int'(Count) == TMO) begin
                 ph = P_REPORT; m_res = 13'(TMO); m_tmo = 1'b1;
               end
        P_REPORT: begin
          ph = P_IDLE;
          if (!m_tmo && m_res < m_best) m_best = m_res;
        end
        default: begin ph = P_IDLE; m_fs = 1'b1; end
      endcase
    end
    m_sprev  = Reset ? 1'b0 : Start;
    m_bprev  = Reset ? 1'b0 : Button;
    m_s2prev = Reset ? 1'b0 : start2;
    m_lfsr   = Reset ? SEED : lfsr_step(m_lfsr);
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // counts fore-period ticks (seen while busy and dark) until the light comes on
  task automatic wait_go(input bit sel, output int nt);
    int b = 0;
    nt = 0;
    do begin
      @(negedge Clock); b++;
      if ((sel ? busy2 : Busy) && !(sel ? go2 : GoLed) && MsTick) nt++;
    end while (!(sel ? go2 : GoLed) && b < 5000);
    if (!(sel ? go2 : GoLed)) begin
      checks++; failures++;
      $display("FAIL wait_go: GoLed still 0 after %0d cycles, want 1", b);
    end
    @(posedge Clock); #1;
  endtask

  task automatic wait_arm_ticks(input int n);
    int b = 0, t = 0;
    do begin
      @(negedge Clock); b++;
      if (Busy && !GoLed && MsTick) t++;
    end while (t < n && b < 5000);
    if (t < n) begin
      checks++; failures++;
      $display("FAIL wait_arm_ticks: saw %0d ticks, want %0d", t, n);
    end
    @(posedge Clock); #1;
  endtask

  task automatic wait_count(input int tgt);
    int b = 0;
    do begin @(negedge Clock); b++; end while (int'(Count) != tgt && b < 20000);
    if (int'(Count) != tgt) begin
      checks++; failures++;
      $display("FAIL wait_count: Count %0d, want %0d", Count, tgt);
    end
    @(posedge Clock); #1;
  endtask

  task automatic rv_window(input int n, output int nrv);
    nrv = 0;
    repeat (n) begin @(negedge Clock); if (ResultValid) nrv++; end
    @(posedge Clock); #1;
  endtask

  task automatic wait_rv();
    int b = 0;
    do begin @(negedge Clock); b++; end while (!ResultValid && b < 20000);
    if (!ResultValid) begin
      checks++; failures++;
      $display("FAIL wait_rv: ResultValid still 0 after %0d cycles, want 1", b);
    end
    @(posedge Clock); #1;
  endtask

  task automatic round(input int react);
    int nt, nrv;
    step(2); Start = 1'b1; wait_go(1'b0, nt); Start = 1'b0;
    wait_count(react); Button = 1'b1; rv_window(4, nrv); Button = 1'b0;
    check("round_result", Result, react);
  endtask

  int nt, nrv;
  initial begin
    // reset state
    step(3);
    @(negedge Clock);
    check("rst_GoLed", GoLed, 0);   check("rst_CntReset", CntReset, 1);
    check("rst_Busy", Busy, 0);     check("rst_Result", Result, 0);
    check("rst_FalseStart", FalseStart, 0);
    @(posedge Clock); #1 Reset = 1'b0;
    step(2);

    // 1: fixed fore-period, reaction of 250 ms
    Start = 1'b1; wait_go(1'b0, nt); Start = 1'b0;
    check("t1_arm_ticks", nt, 1001);
    wait_count(250); Button = 1'b1; rv_window(6, nrv); Button = 1'b0;
    check("t1_rv_pulses", nrv, 1);
    check("t1_result", Result, 250);

    // 2: early press is a foul; the next Start clears it
    step(2); Start = 1'b1; wait_arm_ticks(400);
    Button = 1'b1; rv_window(4, nrv); Button = 1'b0; Start = 1'b0;
    check("t2_rv_pulses", nrv, 0);
    @(negedge Clock);
    check("t2_false_start", FalseStart, 1);
    check("t2_idle", Busy, 0);
    check("t2_result_held", Result, 250);
    step(2); Start = 1'b1; step(2);
    @(negedge Clock);
    check("t2_fs_cleared", FalseStart, 0);

    // 3: same round runs to the timeout
    wait_go(1'b0, nt); Start = 1'b0;
    wait_rv();
    check("t3_timeout_result", Result, 8191);
    step(2);
    @(negedge Clock);
    check("t3_idle", Busy, 0);

    // 4: button held through arming never fouls or reports
    step(1); Button = 1'b1; step(2); Start = 1'b1;
    wait_go(1'b0, nt); Start = 1'b0;
    check("t4_arm_ticks", nt, 1001);
    wait_count(20); Button = 1'b0;
    wait_count(37); Button = 1'b1; rv_window(6, nrv); Button = 1'b0;
    check("t4_rv_pulses", nrv, 1);
    check("t4_result", Result, 37);
    check("t4_no_foul", FalseStart, 0);

    // 5: reset in the middle of GO
    step(2); Start = 1'b1; wait_go(1'b0, nt); Start = 1'b0;
    wait_count(100); Reset = 1'b1; step(1); Reset = 1'b0;
    @(negedge Clock);
    check("t5_GoLed", GoLed, 0);    check("t5_CntReset", CntReset, 1);
    check("t5_Result", Result, 0);  check("t5_Busy", Busy, 0);
    step(2);

    // 6: best time across rounds, unaffected by a timeout
    round(300); round(180); round(220);
`ifdef REACTION_BEST_TIME_EN
    check("t6_best", BestTime, 180);
`endif
    step(2); Start = 1'b1; wait_go(1'b0, nt); Start = 1'b0;
    wait_rv();
    check("t6_timeout_result", Result, 8191);
    step(2);
`ifdef REACTION_BEST_TIME_EN
    check("t6_best_after_timeout", BestTime, 180);
`endif

    // random fore-period on the second instance follows the LFSR
    for (int r = 0; r < 4; r++) begin
      step($urandom_range(1, 9));
      start2 = 1'b1; wait_go(1'b1, nt); start2 = 1'b0;
      check("rnd_arm_ticks", nt, exp_arm2);
      button2 = 1'b1; step(3); button2 = 1'b0; step(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
